// File: rtl/cdb_slot_scheduler_pkg.sv
// Shared types and constants for the CDB slot scheduler.
//   cdb_bus_t   : one result bus {valid, tag, data}, used for FU inputs and the broadcast CDB.
//   rsv_entry_t : one reservation-table slot {valid, fu_id}.
//   FU_*        : functional-unit index constants (int, mem, mult, div).
//   rr_dist     : round-robin distance of an index from the pointer, with wrap-around.
package cdb_slot_scheduler_pkg;

  localparam int unsigned TAG_W      = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FU_ID_W    = 2;
  localparam int unsigned NUM_FU_MAX = 1 << FU_ID_W;

  localparam int unsigned FU_INT  = 0;
  localparam int unsigned FU_MEM  = 1;
  localparam int unsigned FU_MULT = 2;
  localparam int unsigned FU_DIV  = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_bus_t;

  typedef struct packed {
    logic               valid;
    logic [FU_ID_W-1:0] fu_id;
  } rsv_entry_t;

  // Smaller distance = higher priority; the pointer itself has distance 0.
  function automatic int unsigned rr_dist(int unsigned idx, int unsigned ptr, int unsigned n);
    return (idx + n - ptr) % n;
  endfunction

endpackage

// File: rtl/cdb_slot_scheduler_if.sv
// Bus bundle between the issue side and the CDB scheduler.
//   master : issue queues / FUs drive issue_req, flush, fu_cdb; observe grants and the CDB.
//   slave  : the scheduler consumes requests and FU results, drives grants, CDB and status.
interface cdb_slot_scheduler_if
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned CNT_W  = 16
);

  logic     [NUM_FU-1:0] issue_req;
  logic                  flush;
  cdb_bus_t [NUM_FU-1:0] fu_cdb;
  logic     [NUM_FU-1:0] issue_gnt;
  cdb_bus_t              cdb_out;
  logic     [NUM_FU-1:0] cdb_sel;
  logic                  err_missing;
  logic     [CNT_W-1:0]  conflict_cnt;

  modport master (
    output issue_req, flush, fu_cdb,
    input  issue_gnt, cdb_out, cdb_sel, err_missing, conflict_cnt
  );

  modport slave (
    input  issue_req, flush, fu_cdb,
    output issue_gnt, cdb_out, cdb_sel, err_missing, conflict_cnt
  );

endinterface

// File: rtl/cdb_slot_arbiter.sv
// Combinational same-latency arbiter.
//   req_i        : requests already qualified by flush.
//   free_i       : per-FU "target slot is free".
//   same_lat_i   : [i][j] set when FU i and FU j share a latency (only those compete).
//   rr_ptr_i     : round-robin pointer (ignored when ARB_MODE == 0).
//   gnt_o        : grants; at most one per latency group.
//   tie_o        : some group had more than one candidate this cycle.
//   tie_winner_o : winner of the lowest-index contested group.
module cdb_slot_arbiter
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FU   = 4,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic [NUM_FU-1:0]             req_i,
  input  logic [NUM_FU-1:0]             free_i,
  input  logic [NUM_FU-1:0][NUM_FU-1:0] same_lat_i,
  input  logic [FU_ID_W-1:0]            rr_ptr_i,
  output logic [NUM_FU-1:0]             gnt_o,
  output logic                          tie_o,
  output logic [FU_ID_W-1:0]            tie_winner_o
);

  logic [NUM_FU-1:0] cand;
  logic              beaten;
  logic              rival;

  assign cand = req_i & free_i;

  always_comb begin
    gnt_o        = '0;
    tie_o        = 1'b0;
    tie_winner_o = '0;
    beaten       = 1'b0;
    rival        = 1'b0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      beaten = 1'b0;
      rival  = 1'b0;
      for (int unsigned j = 0; j < NUM_FU; j++) begin
        if (j != i && cand[j] && same_lat_i[i][j]) begin
          rival = 1'b1;
          if (ARB_MODE == 1) begin
            if (rr_dist(j, 32'(rr_ptr_i), NUM_FU) < rr_dist(i, 32'(rr_ptr_i), NUM_FU)) begin
              beaten = 1'b1;
            end
          end else if (j < i) begin
            beaten = 1'b1;
          end
        end
      end
      if (cand[i] && !beaten) begin
        gnt_o[i] = 1'b1;
        if (rival && !tie_o) begin
          tie_o        = 1'b1;
          tie_winner_o = FU_ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// Common Data Bus slot scheduler.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : slave side of cdb_slot_scheduler_if (requests, flush, FU results in;
//                grants, CDB broadcast, owner one-hot, sticky error, conflict count out).
// A DEPTH-entry reservation shift register records which FU owns each future CDB cycle;
// entry 0 is the owner of the current cycle. An FU with latency L may issue only when
// entry L is free, and a grant books entry L-1 so it lands in entry 0 L cycles later.
module cdb_slot_scheduler
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FU           = 4,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned FU_LAT [NUM_FU]  = '{1, 1, 4, 7},
  parameter int unsigned ARB_MODE         = 0,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cdb_slot_scheduler_if.slave  bus
);

  rsv_entry_t [DEPTH-1:0]        rsv_q, rsv_d;
  logic       [FU_ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                          err_q, err_d;
  logic       [CNT_W-1:0]        cnt_q, cnt_d;

  logic       [NUM_FU-1:0]             slot_free;
  logic       [NUM_FU-1:0]             arb_req;
  logic       [NUM_FU-1:0]             gnt;
  logic       [NUM_FU-1:0][NUM_FU-1:0] same_lat;
  logic                                tie;
  logic       [FU_ID_W-1:0]            tie_winner;
  cdb_bus_t                            sel_bus;

  if (NUM_FU < 2 || NUM_FU > NUM_FU_MAX) begin : g_bad_num_fu
    $fatal(1, "cdb_slot_scheduler: NUM_FU out of range");
  end

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    if (FU_LAT[i] < 1 || FU_LAT[i] > DEPTH) begin : g_bad_lat
      $fatal(1, "cdb_slot_scheduler: FU_LAT out of 1..DEPTH");
    end
    // A latency equal to DEPTH looks past the end of the table, so it is never blocked.
    if (FU_LAT[i] >= DEPTH) begin : g_always_free
      assign slot_free[i] = 1'b1;
    end else begin : g_table_free
      assign slot_free[i] = ~rsv_q[FU_LAT[i]].valid;
    end
    for (genvar j = 0; j < NUM_FU; j++) begin : g_grp
      assign same_lat[i][j] = (FU_LAT[i] == FU_LAT[j]);
    end
  end

  assign arb_req = bus.issue_req & {NUM_FU{~bus.flush}};

  cdb_slot_arbiter #(
    .NUM_FU   (NUM_FU),
    .ARB_MODE (ARB_MODE)
  ) u_arbiter (
    .req_i        (arb_req),
    .free_i       (slot_free),
    .same_lat_i   (same_lat),
    .rr_ptr_i     (rr_ptr_q),
    .gnt_o        (gnt),
    .tie_o        (tie),
    .tie_winner_o (tie_winner)
  );

  assign sel_bus = bus.fu_cdb[rsv_q[0].fu_id];

  always_comb begin
    bus.issue_gnt    = gnt;
    bus.err_missing  = err_q;
    bus.conflict_cnt = cnt_q;
    bus.cdb_out      = '0;
    bus.cdb_sel      = '0;
    if (rsv_q[0].valid) begin
      bus.cdb_out = sel_bus;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        bus.cdb_sel[i] = (rsv_q[0].fu_id == FU_ID_W'(i));
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
      rsv_d[k] = rsv_q[k+1];
    end
    rsv_d[DEPTH-1] = '0;
    // Bookings override the shifted-in value; granted FUs never share a latency.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (gnt[i] && FU_LAT[i] == k + 1) begin
          rsv_d[k].valid = 1'b1;
          rsv_d[k].fu_id = FU_ID_W'(i);
        end
      end
    end
    if (bus.flush) begin
      rsv_d = '0;
    end

    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == 1 && tie) begin
      rr_ptr_d = (tie_winner == FU_ID_W'(NUM_FU - 1)) ? '0 : tie_winner + 1'b1;
    end

    err_d = err_q | (rsv_q[0].valid & ~sel_bus.valid);

    cnt_d = cnt_q;
    if (|(bus.issue_req & ~gnt) && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_q    <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rsv_q    <= rsv_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed bench: dut0 is fixed priority with a 16-bit counter, dut1 is round-robin with a
// 3-bit counter so saturation is reachable. Both see the same stimulus.
module tb_cdb_slot_scheduler;
  import cdb_slot_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_bus_t fu_pat [4];

  cdb_slot_scheduler_if #(.NUM_FU(4), .CNT_W(16)) if0 ();
  cdb_slot_scheduler_if #(.NUM_FU(4), .CNT_W(3))  if1 ();

  cdb_slot_scheduler #(.ARB_MODE(0), .CNT_W(16)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  cdb_slot_scheduler #(.ARB_MODE(1), .CNT_W(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic fl);
    if0.issue_req = req;
    if1.issue_req = req;
    if0.flush     = fl;
    if1.flush     = fl;
  endtask

  task automatic set_fu_valid(input int idx, input logic v);
    if0.fu_cdb[idx].valid = v;
    if1.fu_cdb[idx].valid = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cdb0(input string tag, input logic [3:0] exp_sel);
    cdb_bus_t exp_out;
    exp_out = '0;
    for (int i = 0; i < 4; i++) if (exp_sel[i]) exp_out = fu_pat[i];
    check_eq({tag, "_sel"}, 64'(if0.cdb_sel), 64'(exp_sel));
    check_eq({tag, "_out"}, 64'(if0.cdb_out), 64'(exp_out));
  endtask

  logic [3:0] par_sel [1:8];

  initial begin
    for (int i = 0; i < 4; i++) begin
      fu_pat[i].valid = 1'b1;
      fu_pat[i].tag   = 6'(i + 10);
      fu_pat[i].data  = 32'hC0DE_0000 + 32'(i * 17);
      if0.fu_cdb[i]   = fu_pat[i];
      if1.fu_cdb[i]   = fu_pat[i];
    end
    par_sel = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    drive(4'b0000, 1'b0);

    // Reset state
    #2;
    chk_cdb0("rst", 4'b0000);
    check_eq("rst_err", 64'(if0.err_missing), 64'(0));
    check_eq("rst_cnt", 64'(if0.conflict_cnt), 64'(0));
    check_eq("rst_gnt_idle", 64'(if0.issue_gnt), 64'(0));
    drive(4'b0001, 1'b0);
    #1;
    check_eq("rst_gnt_req", 64'(if0.issue_gnt), 64'(4'b0001));
    drive(4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Single int issue
    drive(4'b0001, 1'b0);
    #1;
    check_eq("int_gnt", 64'(if0.issue_gnt), 64'(4'b0001));
    check_eq("int_sel_t0", 64'(if0.cdb_sel), 64'(0));
    next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    chk_cdb0("int_t1", 4'b0001);
    next_cycle();
    #1;
    chk_cdb0("int_t2", 4'b0000);

    // Int/mem collision: fixed priority vs round-robin
    drive(4'b0011, 1'b0);
    #1;
    check_eq("col_g0_c0", 64'(if0.issue_gnt), 64'(4'b0001));
    check_eq("col_g1_c0", 64'(if1.issue_gnt), 64'(4'b0001));
    next_cycle();
    #1;
    check_eq("col_cnt0_c1", 64'(if0.conflict_cnt), 64'(1));
    check_eq("col_g0_c1", 64'(if0.issue_gnt), 64'(4'b0001));
    check_eq("col_g1_c1", 64'(if1.issue_gnt), 64'(4'b0010));
    next_cycle();
    #1;
    check_eq("col_g0_c2", 64'(if0.issue_gnt), 64'(4'b0001));
    check_eq("col_g1_c2", 64'(if1.issue_gnt), 64'(4'b0001));
    check_eq("col_sel1_c2", 64'(if1.cdb_sel), 64'(4'b0010));
    next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    check_eq("col_cnt0_end", 64'(if0.conflict_cnt), 64'(3));
    check_eq("col_cnt1_end", 64'(if1.conflict_cnt), 64'(3));
    next_cycle();

    // Div books slot 7; int aiming at the same slot is denied, then granted a cycle later
    drive(4'b1000, 1'b0);
    #1;
    check_eq("div_gnt", 64'(if0.issue_gnt), 64'(4'b1000));
    next_cycle();
    drive(4'b0000, 1'b0);
    repeat (5) next_cycle();
    drive(4'b0001, 1'b0);
    #1;
    check_eq("int_denied_t6", 64'(if0.issue_gnt), 64'(4'b0000));
    next_cycle();
    #1;
    check_eq("int_gnt_t7", 64'(if0.issue_gnt), 64'(4'b0001));
    chk_cdb0("div_t7", 4'b1000);
    check_eq("cnt0_t7", 64'(if0.conflict_cnt), 64'(4));
    next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    chk_cdb0("int_t8", 4'b0001);
    next_cycle();

    // Parallel grant to int, mult, div
    drive(4'b1101, 1'b0);
    #1;
    check_eq("par_gnt", 64'(if0.issue_gnt), 64'(4'b1101));
    next_cycle();
    drive(4'b0000, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      #1;
      chk_cdb0($sformatf("par_t%0d", t), par_sel[t]);
      next_cycle();
    end

    // Flush kills a booked mult result and masks grants
    drive(4'b0100, 1'b0);
    #1;
    check_eq("fl_mult_gnt", 64'(if0.issue_gnt), 64'(4'b0100));
    next_cycle();
    drive(4'b0000, 1'b0);
    next_cycle();
    drive(4'b0001, 1'b1);
    #1;
    check_eq("fl_gnt_t2", 64'(if0.issue_gnt), 64'(0));
    next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    check_eq("fl_cnt_kept", 64'(if0.conflict_cnt), 64'(5));
    next_cycle();
    #1;
    chk_cdb0("fl_t4", 4'b0000);
    next_cycle();

    // Asynchronous reset mid-operation
    drive(4'b0001, 1'b0);
    #1;
    check_eq("ar_gnt", 64'(if0.issue_gnt), 64'(4'b0001));
    next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    chk_cdb0("ar_before", 4'b0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cdb0("ar_after", 4'b0000);
    check_eq("ar_cnt0", 64'(if0.conflict_cnt), 64'(0));
    check_eq("ar_cnt1", 64'(if1.conflict_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    // Round-robin pointer back to 0 after reset
    drive(4'b0011, 1'b0);
    #1;
    check_eq("rr_after_rst", 64'(if1.issue_gnt), 64'(4'b0001));
    next_cycle();
    drive(4'b0000, 1'b0);
    next_cycle();

    // Missing result during a reserved mult slot: sticky through flush, cleared by reset
    drive(4'b0100, 1'b0);
    #1;
    next_cycle();
    drive(4'b0000, 1'b0);
    repeat (3) next_cycle();
    set_fu_valid(FU_MULT, 1'b0);
    #1;
    check_eq("pe_sel", 64'(if0.cdb_sel), 64'(4'b0100));
    check_eq("pe_err_before", 64'(if0.err_missing), 64'(0));
    next_cycle();
    set_fu_valid(FU_MULT, 1'b1);
    #1;
    check_eq("pe_err_set", 64'(if0.err_missing), 64'(1));
    drive(4'b0000, 1'b1);
    next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    check_eq("pe_err_flush", 64'(if0.err_missing), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("pe_err_rst", 64'(if0.err_missing), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Counter saturation (dut1 counter is 3 bits wide)
    drive(4'b0011, 1'b0);
    repeat (9) next_cycle();
    drive(4'b0000, 1'b0);
    #1;
    check_eq("sat_cnt0", 64'(if0.conflict_cnt), 64'(9));
    check_eq("sat_cnt1", 64'(if1.conflict_cnt), 64'(7));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
